fifo_wr_arb_ctrl: RTL

- Write-side controller for the 8-entry, 16-bit async FIFO dual-port memory.
- Arbitrates two write requesters onto the single memory write port using round-robin.
- Owns the write pointer (binary and Gray) and synchronises the read-domain Gray pointer into wclk.
- Generates full and almost-full flags and drives the memory's waddr, wdata and wen.

---
 rtl/fifo_wr_arb_ctrl.sv | 132 +++++++++++++
 1 files changed

// File: rtl/fifo_wr_arb_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fifo_wr_arb_ctrl : round-robin write arbiter, write pointers and full/count
//                    flags for the write side of an async FIFO.
//                    Optional: FIFO_WR_OVERFLOW_CNT_EN adds an overflow counter.
// Revision: 1.0
// ---------------------------------------------------------------------------
module fifo_wr_arb_ctrl #(
  parameter int DW        = 16,
  parameter int AW        = 3,
  parameter int AF_MARGIN = 2
) (
  input  logic          wclk,
  input  logic          wrst_n,
  input  logic          req0,
  input  logic [DW-1:0] wdata0,
  output logic          gnt0,
  input  logic          req1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt1,
  input  logic [AW:0]   rptr_gray,
  output logic [AW:0]   wptr_gray,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  output logic          wen,
  output logic          wfull,
  output logic          walmost_full,
`ifdef FIFO_WR_OVERFLOW_CNT_EN
  input  logic          ovf_clr,
  output logic [7:0]    ovf_cnt,
`endif
  output logic [AW:0]   wcount
);

  localparam int          c_depth     = 1 << AW;
  localparam logic [AW:0] c_af_thresh = (AW+1)'(c_depth - AF_MARGIN);

  function automatic logic [AW:0] gray2bin(input logic [AW:0] g);
    logic [AW:0] b;
    b[AW] = g[AW];
    for (int i = AW - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  logic [AW:0] r_wbin;
  logic [AW:0] r_wptr_gray;
  logic [AW:0] r_rq1;
  logic [AW:0] r_rq2;
  logic        r_wfull;
  logic        r_walmost_full;
  logic [AW:0] r_wcount;
  logic        r_last;

  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_wen;
  logic [AW:0] w_wbin_next;
  logic [AW:0] w_wgray_next;
  logic [AW:0] w_count_next;
  logic        w_full_next;

  // Grants are forced low while reset is held so no write can slip through.
  always_comb begin
    w_gnt0 = 1'b0;
    w_gnt1 = 1'b0;
    if (wrst_n && !r_wfull) begin
      if (req0 && req1) begin
        w_gnt0 = r_last;
        w_gnt1 = ~r_last;
      end else begin
        w_gnt0 = req0;
        w_gnt1 = req1;
      end
    end
  end

  assign w_wen        = w_gnt0 | w_gnt1;
  assign w_wbin_next  = r_wbin + {{AW{1'b0}}, w_wen};
  assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);
  assign w_count_next = w_wbin_next - gray2bin(r_rq2);
  assign w_full_next  = (w_wgray_next == {~r_rq2[AW:AW-1], r_rq2[AW-2:0]});

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_wbin         <= '0;
      r_wptr_gray    <= '0;
      r_rq1          <= '0;
      r_rq2          <= '0;
      r_wfull        <= 1'b0;
      r_walmost_full <= 1'b0;
      r_wcount       <= '0;
      r_last         <= 1'b1;
    end else begin
      r_rq1          <= rptr_gray;
      r_rq2          <= r_rq1;
      r_wbin         <= w_wbin_next;
      r_wptr_gray    <= w_wgray_next;
      r_wfull        <= w_full_next;
      r_wcount       <= w_count_next;
      r_walmost_full <= (w_count_next >= c_af_thresh);
      if (w_wen) r_last <= w_gnt1;
    end
  end

`ifdef FIFO_WR_OVERFLOW_CNT_EN
  logic [7:0] r_ovf_cnt;

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      r_ovf_cnt <= '0;
    end else if (ovf_clr) begin
      r_ovf_cnt <= '0;
    end else if ((req0 | req1) && r_wfull && (r_ovf_cnt != 8'hFF)) begin
      r_ovf_cnt <= r_ovf_cnt + 8'd1;
    end
  end

  assign ovf_cnt = r_ovf_cnt;
`endif

  assign gnt0         = w_gnt0;
  assign gnt1         = w_gnt1;
  assign wen          = w_wen;
  assign waddr        = r_wbin[AW-1:0];
  assign wdata        = w_gnt1 ? wdata1 : wdata0;
  assign wptr_gray    = r_wptr_gray;
  assign wfull        = r_wfull;
  assign walmost_full = r_walmost_full;
  assign wcount       = r_wcount;

endmodule
`default_nettype wire
